// File: rtl/axis_read_stream.sv
// axis_read_stream
//   AXI read-data channel to stream converter. Each AXI_DATA_WIDTH read beat
//   is split into RATIO = AXI_DATA_WIDTH/DATA_WIDTH words (least significant
//   word first). The words pass through a show-ahead word buffer. From there
//   they go to a valid/ready output register, framed by lengths taken from a
//   command queue.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_length/valid    stream length (in DATA_WIDTH words) offer
//   cfg_ready           command queue has room (low during rst)
//   axi_r*              AXI read-data channel; rlast is not used for framing
//   data/last/error     output word, end-of-stream marker, word came from rresp!=0
//   valid/ready         output handshake
//   busy                FSM not idle or commands pending
//   status_err          sticky: an errored word has been presented
module axis_read_stream #(
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_AWIDTH     = 3,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      last,
  output logic                      error,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy,
  output logic                      status_err
);

  localparam int RATIO     = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int SUBW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CNTW      = $clog2(RATIO + 1);
  localparam int BUF_DEPTH = 1 << BUF_AWIDTH;
  localparam int CFG_DEPTH = 1 << CFG_AWIDTH;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;

  // Framing ignores rlast; lengths come from the command queue only.
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  // ---------------------------------------------------------------- command queue
  logic [CONFIG_DWIDTH-1:0] cq_mem [CFG_DEPTH];
  logic [CFG_AWIDTH:0]      cq_wr_q, cq_rd_q;
  logic                     cq_empty, cq_full, cq_push, cq_pop;
  logic [CONFIG_DWIDTH-1:0] cq_head;
  state_e                   state_q;

  assign cq_empty  = (cq_wr_q == cq_rd_q);
  assign cq_full   = (cq_wr_q[CFG_AWIDTH] != cq_rd_q[CFG_AWIDTH]) &&
                     (cq_wr_q[CFG_AWIDTH-1:0] == cq_rd_q[CFG_AWIDTH-1:0]);
  assign cfg_ready = ~rst & ~cq_full;
  assign cq_push   = cfg_valid & cfg_ready;
  assign cq_pop    = (state_q == IDLE) & ~cq_empty;
  assign cq_head   = cq_mem[cq_rd_q[CFG_AWIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_wr_q <= '0;
      cq_rd_q <= '0;
    end else begin
      if (cq_push) cq_wr_q <= cq_wr_q + 1'b1;
      if (cq_pop)  cq_rd_q <= cq_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wr_q[CFG_AWIDTH-1:0]] <= cfg_length;
  end

  // ---------------------------------------------------------------- word buffer
  logic [DATA_WIDTH:0]   buf_mem [BUF_DEPTH];
  logic [BUF_AWIDTH:0]   buf_wr_q, buf_rd_q;
  logic                  buf_empty, buf_full, buf_push, buf_pop;
  logic [DATA_WIDTH:0]   buf_wdata, buf_head;

  assign buf_empty = (buf_wr_q == buf_rd_q);
  assign buf_full  = (buf_wr_q[BUF_AWIDTH] != buf_rd_q[BUF_AWIDTH]) &&
                     (buf_wr_q[BUF_AWIDTH-1:0] == buf_rd_q[BUF_AWIDTH-1:0]);
  assign buf_head  = buf_mem[buf_rd_q[BUF_AWIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_wr_q <= '0;
      buf_rd_q <= '0;
    end else begin
      if (buf_push) buf_wr_q <= buf_wr_q + 1'b1;
      if (buf_pop)  buf_rd_q <= buf_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_push) buf_mem[buf_wr_q[BUF_AWIDTH-1:0]] <= buf_wdata;
  end

  // ---------------------------------------------------------------- serializer
  // ser_cnt_q = words of the held beat not yet written to the buffer.
  // A beat accepted with an empty serializer writes its low word straight
  // into the buffer, which gives the two-cycle beat-to-valid latency.
  // A beat accepted while the last residue word drains is held whole,
  // because the buffer has a single write port.
  logic [AXI_DATA_WIDTH-1:0] ser_data_q, ser_data_d;
  logic                      ser_err_q, ser_err_d;
  logic [CNTW-1:0]           ser_cnt_q, ser_cnt_d;
  logic                      beat_acc, beat_err;

  assign beat_err   = |axi_rresp;
  assign axi_rready = ~rst & ~buf_full &
                      ((ser_cnt_q == '0) | (ser_cnt_q == CNTW'(1)));
  assign beat_acc   = axi_rvalid & axi_rready;

  always_comb begin
    ser_data_d = ser_data_q;
    ser_err_d  = ser_err_q;
    ser_cnt_d  = ser_cnt_q;
    buf_push   = 1'b0;
    buf_wdata  = {ser_err_q, ser_data_q[DATA_WIDTH-1:0]};
    if ((ser_cnt_q != '0) && !buf_full) begin
      buf_push   = 1'b1;
      ser_data_d = ser_data_q >> DATA_WIDTH;
      ser_cnt_d  = ser_cnt_q - CNTW'(1);
    end
    if (beat_acc) begin
      ser_err_d = beat_err;
      if (ser_cnt_q == '0) begin
        buf_push   = 1'b1;
        buf_wdata  = {beat_err, axi_rdata[DATA_WIDTH-1:0]};
        ser_data_d = axi_rdata >> DATA_WIDTH;
        ser_cnt_d  = CNTW'(RATIO - 1);
      end else begin
        ser_data_d = axi_rdata;
        ser_cnt_d  = CNTW'(RATIO);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_data_q <= '0;
      ser_err_q  <= 1'b0;
      ser_cnt_q  <= '0;
    end else begin
      ser_data_q <= ser_data_d;
      ser_err_q  <= ser_err_d;
      ser_cnt_q  <= ser_cnt_d;
    end
  end

  // ---------------------------------------------------------------- framing FSM
  logic [CONFIG_DWIDTH-1:0] len_q, word_cnt_q;
  logic [SUBW-1:0]          sub_idx_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     valid_q, last_q, error_q, status_err_q;
  logic                     load, sub_wrap, is_last;

  assign load     = (state_q == ACTIVE) & (~valid_q | ready) & ~buf_empty;
  assign buf_pop  = load | ((state_q == FLUSH) & ~buf_empty);
  // sub_idx tracks the position within an AXI beat of the word being popped.
  assign sub_wrap = (sub_idx_q == SUBW'(RATIO - 1));
  assign is_last  = (word_cnt_q == len_q - CONFIG_DWIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      sub_idx_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      status_err_q <= 1'b0;
    end else begin
      if (buf_pop) sub_idx_q <= sub_wrap ? '0 : sub_idx_q + SUBW'(1);
      if (valid_q && ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Zero-length commands are popped and dropped here.
          if (!cq_empty) begin
            len_q <= cq_head;
            if (cq_head != '0) begin
              word_cnt_q <= '0;
              state_q    <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (load) begin
            valid_q    <= 1'b1;
            data_q     <= buf_head[DATA_WIDTH-1:0];
            error_q    <= buf_head[DATA_WIDTH];
            last_q     <= is_last;
            word_cnt_q <= word_cnt_q + CONFIG_DWIDTH'(1);
            if (buf_head[DATA_WIDTH]) status_err_q <= 1'b1;
            // Beat-aligned end returns straight to IDLE, otherwise drop the tail.
            if (is_last) state_q <= sub_wrap ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          if (!buf_empty && sub_wrap) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign last       = last_q;
  assign error      = error_q;
  assign valid      = valid_q;
  assign status_err = status_err_q;
  assign busy       = (state_q != IDLE) | ~cq_empty;

endmodule

// File: tb/tb_axis_read_stream.sv
// Directed bench for axis_read_stream with RATIO=2 and a 4-entry word buffer.
module tb_axis_read_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  axi_rresp = 2'b00;
  logic        axi_rlast;
  logic [63:0] axi_rdata = '0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;
  logic [31:0] data;
  logic        last, error, valid, ready, busy, status_err;

  int checks = 0;
  int failures = 0;
  int stab_err = 0;

  logic [65:0] bq[$];   // {rresp, rdata} beats waiting to be offered
  logic [33:0] oq[$];   // {error, last, data} words accepted at the output
  logic        rd_hs;
  logic        stall_prev = 1'b0;
  logic [33:0] prev_out;

  axis_read_stream #(
    .BUF_AWIDTH(2), .CFG_AWIDTH(3), .CONFIG_DWIDTH(32),
    .AXI_DATA_WIDTH(64), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .data(data), .last(last), .error(error), .valid(valid), .ready(ready),
    .busy(busy), .status_err(status_err)
  );

  always #5 clk = ~clk;

  // Inputs only move 1 time unit after posedge, so negedge values decide
  // the handshakes of the following posedge.
  always @(negedge clk) begin
    rd_hs = axi_rvalid && axi_rready;
    if (!rst && valid && ready) oq.push_back({error, last, data});
    if (!rst && stall_prev && (valid !== 1'b1 || {error, last, data} !== prev_out))
      stab_err++;
    stall_prev = !rst && valid && !ready;
    prev_out   = {error, last, data};
  end

  // Beat driver: keeps rvalid up while beats are queued.
  always @(posedge clk) begin
    logic [65:0] dropped;
    #1;
    if (rd_hs && bq.size() > 0) dropped = bq.pop_front();
    if (bq.size() > 0) begin
      axi_rvalid = 1'b1;
      axi_rdata  = bq[0][63:0];
      axi_rresp  = bq[0][65:64];
    end else begin
      axi_rvalid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cfg(input logic [31:0] len);
    cfg_length = len;
    cfg_valid  = 1'b1;
    chk("cfg_ready_on_push", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [1:0] resp, input logic [31:0] hi, input logic [31:0] lo);
    bq.push_back({resp, hi, lo});
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (oq.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk(tag, oq.size(), n);
  endtask

  task automatic chk_word(input int i, input logic e, input logic l,
                          input logic [31:0] d, input string tag);
    logic [33:0] o;
    o = (i < oq.size()) ? oq[i] : 'x;
    chk($sformatf("%s_w%0d", tag, i), {30'b0, o}, {30'b0, e, l, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ready = 1'b1; cfg_valid = 1'b0; cfg_length = '0; axi_rlast = 1'b0;
    repeat (3) tick();
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_error", error, 0);
    chk("rst_data", data, 0);
    chk("rst_axi_rready", axi_rready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status_err", status_err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_axi_rready", axi_rready, 1);

    // Basic length-4 stream.
    push_cfg(4);
    beat(2'b00, 32'd2, 32'd1);
    beat(2'b00, 32'd4, 32'd3);
    wait_words(4, "t1_count");
    for (int i = 0; i < 4; i++) chk_word(i, 1'b0, i == 3, i + 1, "t1");
    chk("t1_busy_done", busy, 0);
    tick();
    oq.delete();

    // Odd length flushes the unused upper word of the last beat.
    push_cfg(3);
    push_cfg(2);
    beat(2'b00, 32'd2, 32'd1);
    beat(2'b00, 32'd4, 32'd3);
    beat(2'b00, 32'd6, 32'd5);
    wait_words(5, "t2_count");
    chk_word(0, 1'b0, 1'b0, 32'd1, "t2");
    chk_word(1, 1'b0, 1'b0, 32'd2, "t2");
    chk_word(2, 1'b0, 1'b1, 32'd3, "t2");
    chk_word(3, 1'b0, 1'b0, 32'd5, "t2");
    chk_word(4, 1'b0, 1'b1, 32'd6, "t2");
    repeat (5) tick();
    chk("t2_no_extra", oq.size(), 5);
    oq.delete();

    // Zero-length command in the middle produces nothing.
    push_cfg(2);
    push_cfg(0);
    push_cfg(2);
    beat(2'b00, 32'd2, 32'd1);
    beat(2'b00, 32'd4, 32'd3);
    wait_words(4, "t3_count");
    for (int i = 0; i < 4; i++) chk_word(i, 1'b0, (i % 2) == 1, i + 1, "t3");
    repeat (5) tick();
    chk("t3_no_extra", oq.size(), 4);
    chk("t3_busy", busy, 0);
    oq.delete();

    // Backpressure: hold ready low until the buffer fills, then toggle.
    ready = 1'b0;
    push_cfg(8);
    for (int i = 0; i < 4; i++) beat(2'b00, 2 * i + 2, 2 * i + 1);
    repeat (20) tick();
    chk("t4_rready_full", axi_rready, 0);
    chk("t4_valid_held", valid, 1);
    chk("t4_data_held", data, 1);
    chk("t4_none_taken", oq.size(), 0);
    for (int k = 0; k < 80 && oq.size() < 8; k++) begin
      ready = (k % 2) == 0;
      tick();
    end
    ready = 1'b1;
    chk("t4_count", oq.size(), 8);
    for (int i = 0; i < 8; i++) chk_word(i, 1'b0, i == 7, i + 1, "t4");
    chk("t4_stable", stab_err, 0);
    tick();
    oq.delete();

    // Error response on the second beat.
    chk("t5_status_clean", status_err, 0);
    push_cfg(4);
    beat(2'b00, 32'd2, 32'd1);
    beat(2'b10, 32'd4, 32'd3);
    wait_words(4, "t5_count");
    for (int i = 0; i < 4; i++) chk_word(i, i >= 2, i == 3, i + 1, "t5");
    chk("t5_status_set", status_err, 1);
    tick();
    oq.delete();
    push_cfg(2);
    beat(2'b00, 32'd6, 32'd5);
    wait_words(2, "t5b_count");
    chk_word(0, 1'b0, 1'b0, 32'd5, "t5b");
    chk_word(1, 1'b0, 1'b1, 32'd6, "t5b");
    chk("t5b_status_sticky", status_err, 1);
    tick();
    oq.delete();

    // Command queue fill, then reset mid-stream.
    ready = 1'b0;
    push_cfg(100);
    beat(2'b00, 32'd2, 32'd1);
    repeat (5) tick();
    chk("t6_valid_before", valid, 1);
    for (int i = 0; i < 8; i++) push_cfg(2);
    chk("t6_cfg_full", cfg_ready, 0);
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    bq.delete();
    tick();
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cfg_ready", cfg_ready, 0);
    chk("t6_rst_status", status_err, 0);
    rst = 1'b0;
    tick();
    chk("t6_cfg_ready_after", cfg_ready, 1);
    chk("t6_valid_after", valid, 0);
    chk("t6_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_read_stream.md
Name: axis_read_stream

Overview:
- Next-generation AXI read-data channel handler: accepts AXI read beats, splits each AXI_DATA_WIDTH beat into RATIO words of DATA_WIDTH, and delivers them on an AXI-stream style output.
- Output has true valid/ready backpressure, a per-word error flag and a last marker.
- A queue of stream lengths lets several transfers be configured back-to-back.
- Sits between the AXI HP read port and the stream consumers, alongside the address-channel block that issues the matching read bursts.

Parameters:
- BUF_AWIDTH, 9, word buffer depth = 2^BUF_AWIDTH entries of {err, word}.
- CFG_AWIDTH, 3, command queue depth = 2^CFG_AWIDTH lengths.
- CONFIG_DWIDTH, 32, width of cfg_length.
- AXI_DATA_WIDTH, 64, AXI read data width.
- DATA_WIDTH, 32, output word width. RATIO = AXI_DATA_WIDTH/DATA_WIDTH must be a power of 2, >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_length  in  CONFIG_DWIDTH  stream length in DATA_WIDTH words.
- cfg_valid  in  1  command offer.
- cfg_ready  out  1  command queue not full.
- axi_rresp  in  2  AXI read response.
- axi_rlast  in  1  AXI last beat; ignored for framing.
- axi_rdata  in  AXI_DATA_WIDTH  read data.
- axi_rvalid  in  1  beat valid.
- axi_rready  out  1  beat accept.
- data  out  DATA_WIDTH  output word.
- last  out  1  final word of the current stream.
- error  out  1  word came from a beat with rresp != 0.
- valid  out  1  output valid.
- ready  in  1  output accept.
- busy  out  1  state != IDLE or command queue non-empty.
- status_err  out  1  sticky error indicator.

Behaviour:
- Reset state: valid=0, last=0, error=0, data=0, axi_rready=0, cfg_ready=0 during rst, busy=0, status_err=0. Command queue, word buffer, serializer and counters are emptied. State is IDLE.
- Command queue (FIFO):
  - Push when cfg_valid & cfg_ready; cfg_ready = ~queue_full.
  - A push and a pop in the same cycle are both honoured.
- Serializer:
  - axi_rready = 1 when the serializer holds no residue, or when it is emitting its final word of the beat and the buffer accepts that word.
  - A beat is captured when axi_rvalid & axi_rready.
  - Words are emitted least-significant first, one per cycle while the buffer is not full.
  - Every word of the beat carries err = (axi_rresp != 0).
  - Buffer full stalls the serializer, which deasserts axi_rready.
- Word buffer is show-ahead FIFO. Minimum latency from beat accepted in cycle N to first word valid is cycle N+2.
- Output register: data/last/error/valid load from the buffer head when (~valid | ready) & ~buf_empty & state==ACTIVE. Outputs hold stable while valid & ~ready.
- word_cnt (CONFIG_DWIDTH bits) counts words loaded in the current stream. sub_idx (log2 RATIO bits) counts popped words modulo RATIO; it wraps 0..RATIO-1 and is reset only by rst.
- FSM:
  - IDLE: if queue non-empty, pop the command and latch len. If len==0, discard it and stay in IDLE, popping at most one command per cycle. Otherwise clear word_cnt and go to ACTIVE.
  - ACTIVE: load words; last=1 on the word where word_cnt == len-1. After that load: if sub_idx wraps to 0, go to IDLE; else go to FLUSH.
  - FLUSH: pop buffer words without presenting them (1 per cycle while non-empty) until sub_idx wraps to 0, then go to IDLE. This discards the unused tail of the final AXI beat, so the next stream starts beat-aligned.
- Next-command pop is allowed in the cycle after return to IDLE. There is no bubble requirement beyond that single cycle.
- status_err: set when any word with err=1 is loaded to the output; cleared only by rst.
- Lengths are not checked against AXI bursts. Upstream guarantees that beats issued equal ceil(len/RATIO) per command.
- Reset mid-stream: everything is dropped next cycle. Upstream must not deliver beats of pre-reset commands after rst.
- RATIO==1: FLUSH is never entered.

Test Plan:
- RATIO=2, cfg_length=4, beats 0x00000002_00000001, 0x00000004_00000003, ready=1 -> data 1,2,3,4; last only on 4; error=0; busy falls after the final word.
- cfg_length=3 then cfg_length=2; beats {2,1},{4,3},{6,5} -> outputs 1,2,3(last),5,6(last); word 4 flushed and never presented.
- Queue lengths 2,0,2 pushed back-to-back -> 4 words out, last on the 2nd and 4th; the zero-length command produces no output.
- BUF_AWIDTH=2, ready pattern 1,0,1,0 with continuous rvalid -> no word lost or duplicated; data stable while valid & ~ready; axi_rready low whenever 4 words are buffered.
- rresp=2'b10 on the 2nd beat of a length-4 stream -> words 3,4 have error=1; status_err=1 and stays 1 through the next clean stream until rst.
- CFG_AWIDTH=3: 8 pushes with no data -> cfg_ready=0 on the 9th offer. Assert rst mid-stream -> the next cycle shows valid=0, busy=0, and cfg_ready=1 once rst deasserts.
